sram_mem_controller: RTL

// - Sequences the off-chip 16-bit SRAM on behalf of the MEM stage of the 5-stage ARM pipeline.
// - Splits each 32-bit load/store into two half-word accesses (low, then high), each padded with

---
 rtl/sram_mem_controller_pkg.sv | 18 +
 rtl/sram_mem_controller_if.sv | 33 +++
 rtl/sram_mem_controller_wait.sv | 44 ++++
 rtl/sram_mem_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the SRAM memory controller slice.
// Contents:
//   state_t          - controller FSM state encoding
//   DEF_BASE_ADDR    - default byte address that maps to SRAM word 0
//   DEF_WAIT_CYCLES  - default cycles per half-word phase (legal 1..15)
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_BASE_ADDR   = 32'd1024;
    localparam int unsigned DEF_WAIT_CYCLES = 32'd2;

endpackage

// File: rtl/sram_mem_controller_if.sv
// Bus bundle between the MEM stage, the controller and the SRAM pads.
// Pipeline side : rd_en, wr_en, addr, wdata (requests) / rdata, ready (responses)
// SRAM side     : sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n (drive)
//                 sram_dq_in (read data returned by the device)
// Modports: slave = controller, master = pipeline + SRAM device side.
interface sram_mem_controller_if #(
    parameter int unsigned WIDTH   = 32'd32,
    parameter int unsigned SRAM_AW = 32'd18,
    parameter int unsigned SRAM_DW = 32'd16
);
    logic               rd_en;
    logic               wr_en;
    logic [WIDTH-1:0]   addr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic [SRAM_DW-1:0] sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport slave (
        input  rd_en, wr_en, addr, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport master (
        output rd_en, wr_en, addr, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_mem_controller_wait.sv
// Phase timer for the SRAM controller: 4-bit load/decrement counter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - reload with WAIT_CYCLES-1 (asserted on the edge entering a phase)
//   last      - current cycle is the final cycle of the phase (count == 0)
//   last_nxt  - the following cycle will be the final cycle of its phase
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 32'd2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last,
    output logic last_nxt
);
    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 32'd1);

    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;

    // Next count: reload on phase entry, otherwise run down to zero and rest there
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = LOAD_VAL;
        end else if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
        end else begin
            cnt_nxt_s = 4'd0;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign last     = (cnt_r == 4'd0);
    assign last_nxt = (cnt_nxt_s == 4'd0);
endmodule

// File: rtl/sram_mem_controller.sv
// SRAM controller for the MEM stage: each 32-bit load/store becomes two 16-bit
// accesses (low half, then high half), each lasting WAIT_CYCLES cycles.
// Ports:
//   clk  - pipeline clock
//   rst  - synchronous active-high reset; aborts any access in flight
//   bus  - slave modport: pipeline request/response and SRAM pad signals
// ready is combinational (IDLE with no request, or DONE); all SRAM-side
// outputs and rdata are registered, so the SRAM drive for the next cycle is
// computed from the next state and next counter value.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned WIDTH       = 32'd32,
    parameter int unsigned SRAM_AW     = 32'd18,
    parameter int unsigned SRAM_DW     = 32'd16,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input logic                  clk,
    input logic                  rst,
    sram_mem_controller_if.slave bus
);
    state_t             state_r, state_nxt_s;
    logic               load_s, last_s, last_nxt_s;
    logic               req_s, start_s;
    logic               op_wr_r, op_wr_nxt_s;
    logic [SRAM_AW-2:0] hw_base_r, hw_base_nxt_s;
    logic [WIDTH-1:0]   wdata_r, wdata_nxt_s;
    logic [WIDTH-1:0]   off_s;
    logic               unused_off_s;
    logic [WIDTH-1:0]   rdata_r;
    logic               active_nxt_s, phase_nxt_s, hold_cycle_s;
    logic [SRAM_AW-1:0] sram_addr_r, sram_addr_nxt_s;
    logic [SRAM_DW-1:0] sram_dq_out_r, sram_dq_out_nxt_s;
    logic               sram_dq_oe_r, sram_dq_oe_nxt_s;
    logic               sram_we_n_r, sram_we_n_nxt_s;
    logic               sram_oe_n_r, sram_oe_n_nxt_s;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .last     (last_s),
        .last_nxt (last_nxt_s)
    );

    assign req_s   = bus.rd_en | bus.wr_en;
    assign start_s = (state_r == S_IDLE) & req_s;
    // Offset wraps modulo 2^WIDTH; only the word-index bits reach the SRAM
    assign off_s        = bus.addr - WIDTH'(BASE_ADDR);
    assign unused_off_s = ^{off_s[WIDTH-1:SRAM_AW+1], off_s[1:0]};

    // FSM next state; the counter is reloaded on every phase entry
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_s) begin
                    state_nxt_s = S_LOW;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOW: begin
                if (last_s) begin
                    state_nxt_s = S_HIGH;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = S_LOW;
                end
            end
            S_HIGH: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_HIGH;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Operation latch: capture op/offset/data when leaving IDLE (write wins over read)
    always_comb begin
        op_wr_nxt_s   = op_wr_r;
        hw_base_nxt_s = hw_base_r;
        wdata_nxt_s   = wdata_r;
        if (start_s) begin
            op_wr_nxt_s   = bus.wr_en;
            hw_base_nxt_s = off_s[SRAM_AW:2];
            wdata_nxt_s   = bus.wdata;
        end else begin
            op_wr_nxt_s   = op_wr_r;
            hw_base_nxt_s = hw_base_r;
            wdata_nxt_s   = wdata_r;
        end
    end

    // SRAM drive for the coming cycle; write strobe is released on the last
    // cycle of each phase for address/data hold, unless a phase is one cycle
    always_comb begin
        active_nxt_s      = (state_nxt_s == S_LOW) | (state_nxt_s == S_HIGH);
        phase_nxt_s       = (state_nxt_s == S_HIGH);
        hold_cycle_s      = last_nxt_s & (WAIT_CYCLES != 32'd1);
        sram_addr_nxt_s   = '0;
        sram_dq_out_nxt_s = '0;
        sram_dq_oe_nxt_s  = 1'b0;
        sram_we_n_nxt_s   = 1'b1;
        sram_oe_n_nxt_s   = 1'b1;
        if (active_nxt_s) begin
            sram_addr_nxt_s = {hw_base_nxt_s, phase_nxt_s};
            if (op_wr_nxt_s) begin
                sram_dq_oe_nxt_s  = 1'b1;
                sram_we_n_nxt_s   = hold_cycle_s;
                sram_oe_n_nxt_s   = 1'b1;
                sram_dq_out_nxt_s = phase_nxt_s ? wdata_nxt_s[WIDTH-1:SRAM_DW]
                                                : wdata_nxt_s[SRAM_DW-1:0];
            end else begin
                sram_dq_oe_nxt_s  = 1'b0;
                sram_we_n_nxt_s   = 1'b1;
                sram_oe_n_nxt_s   = 1'b0;
                sram_dq_out_nxt_s = '0;
            end
        end else begin
            sram_addr_nxt_s   = '0;
            sram_dq_out_nxt_s = '0;
        end
    end

    // State, operation latch and SRAM output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            op_wr_r       <= 1'b0;
            hw_base_r     <= '0;
            wdata_r       <= '0;
            sram_addr_r   <= '0;
            sram_dq_out_r <= '0;
            sram_dq_oe_r  <= 1'b0;
            sram_we_n_r   <= 1'b1;
            sram_oe_n_r   <= 1'b1;
        end else begin
            state_r       <= state_nxt_s;
            op_wr_r       <= op_wr_nxt_s;
            hw_base_r     <= hw_base_nxt_s;
            wdata_r       <= wdata_nxt_s;
            sram_addr_r   <= sram_addr_nxt_s;
            sram_dq_out_r <= sram_dq_out_nxt_s;
            sram_dq_oe_r  <= sram_dq_oe_nxt_s;
            sram_we_n_r   <= sram_we_n_nxt_s;
            sram_oe_n_r   <= sram_oe_n_nxt_s;
        end
    end

    // Load data capture on the final cycle of each read phase
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if ((state_r == S_LOW) && last_s && !op_wr_r) begin
            rdata_r[SRAM_DW-1:0] <= bus.sram_dq_in;
        end else if ((state_r == S_HIGH) && last_s && !op_wr_r) begin
            rdata_r[WIDTH-1:SRAM_DW] <= bus.sram_dq_in;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.ready       = ((state_r == S_IDLE) & ~bus.rd_en & ~bus.wr_en) | (state_r == S_DONE);
    assign bus.rdata       = rdata_r;
    assign bus.sram_addr   = sram_addr_r;
    assign bus.sram_dq_out = sram_dq_out_r;
    assign bus.sram_dq_oe  = sram_dq_oe_r;
    assign bus.sram_we_n   = sram_we_n_r;
    assign bus.sram_oe_n   = sram_oe_n_r;
endmodule
